// File: rtl/sayeh_pkg.sv
// Shared constants for the SAYEH ALU stage: widths, op codes and FSM states.
package sayeh_pkg;
  localparam int DATA_W = 16;
  localparam int MUL_W  = 8;

  localparam logic [3:0] OP_PASSB = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_NOTB  = 4'd3;
  localparam logic [3:0] OP_SHLB  = 4'd4;
  localparam logic [3:0] OP_SHRB  = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_SUB   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_CMP   = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_FIN
  } state_t;
endpackage

// File: rtl/sayeh_alu_if.sv
// Controller/register-file side bundle of the SAYEH ALU stage.
interface sayeh_alu_if;
  import sayeh_pkg::*;

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [3:0]        op;
  logic              start;
  logic              cset;
  logic              creset;
  logic              zset;
  logic              zreset;
  logic [DATA_W-1:0] result;
  logic              busy;
  logic              done;
  logic              cflag;
  logic              zflag;

  modport master (
    output a, b, op, start, cset, creset, zset, zreset,
    input  result, busy, done, cflag, zflag
  );

  modport slave (
    input  a, b, op, start, cset, creset, zset, zreset,
    output result, busy, done, cflag, zflag
  );
endinterface

// File: rtl/sayeh_alu_mul.sv
// 8x8 unsigned shift-add multiplier: one partial product per step, product valid after 8 steps.
module shift_add_multiplier
  import sayeh_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [MUL_W-1:0]  multiplicand,
  input  logic [MUL_W-1:0]  multiplier,
  output logic [DATA_W-1:0] product,
  output logic [2:0]        count
);
  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] mcand_reg;
  logic [MUL_W-1:0]  mplier_reg;
  logic [2:0]        count_reg;

  // Operands are captured on load so the caller may change its buses mid-multiply.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else if (load) begin
      acc_reg    <= '0;
      mcand_reg  <= {{(DATA_W-MUL_W){1'b0}}, multiplicand};
      mplier_reg <= multiplier;
      count_reg  <= '0;
    end else if (step) begin
      if (mplier_reg[0])
        acc_reg <= acc_reg + mcand_reg;
      mcand_reg  <= {mcand_reg[DATA_W-2:0], 1'b0};
      mplier_reg <= {1'b0, mplier_reg[MUL_W-1:1]};
      count_reg  <= count_reg + 3'd1;
    end
  end

  assign product = acc_reg;
  assign count   = count_reg;
endmodule

// File: rtl/sayeh_alu.sv
// SAYEH registered ALU stage: single-cycle logic/arith ops, multi-cycle MUL, C/Z flags.
module sayeh_alu
  import sayeh_pkg::*;
(
  input logic        clk,
  input logic        reset,
  sayeh_alu_if.slave bus
);
  state_t            state_reg, state_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic [DATA_W-1:0] wr_val, product;
  logic              c_reg, c_next, c_alu;
  logic              z_reg, z_next, z_alu;
  logic              done_reg, done_next;
  logic              wr, mul_load, mul_step;
  logic [2:0]        step_count;
  logic [DATA_W:0]   sum, diff;

  // Bit DATA_W of diff is the borrow out of A - B - C.
  assign sum  = {1'b0, bus.a} + {1'b0, bus.b} + {{DATA_W{1'b0}}, c_reg};
  assign diff = {1'b0, bus.a} - {1'b0, bus.b} - {{DATA_W{1'b0}}, c_reg};

  shift_add_multiplier u_mul (
    .clk          (clk),
    .reset        (reset),
    .load         (mul_load),
    .step         (mul_step),
    .multiplicand (bus.a[MUL_W-1:0]),
    .multiplier   (bus.b[MUL_W-1:0]),
    .product      (product),
    .count        (step_count)
  );

  always_comb begin
    state_next = state_reg;
    wr         = 1'b0;
    wr_val     = result_reg;
    c_alu      = c_reg;
    z_alu      = z_reg;
    done_next  = 1'b0;
    mul_load   = 1'b0;
    mul_step   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            mul_load   = 1'b1;
            state_next = S_MUL;
          end else begin
            done_next = 1'b1;
            case (bus.op)
              OP_PASSB: begin wr = 1'b1; wr_val = bus.b; end
              OP_AND:   begin wr = 1'b1; wr_val = bus.a & bus.b; end
              OP_OR:    begin wr = 1'b1; wr_val = bus.a | bus.b; end
              OP_NOTB:  begin wr = 1'b1; wr_val = ~bus.b; end
              OP_SHLB: begin
                wr     = 1'b1;
                wr_val = {bus.b[DATA_W-2:0], 1'b0};
                c_alu  = bus.b[DATA_W-1];
              end
              OP_SHRB: begin
                wr     = 1'b1;
                wr_val = {1'b0, bus.b[DATA_W-1:1]};
                c_alu  = bus.b[0];
              end
              OP_ADD: begin
                wr     = 1'b1;
                wr_val = sum[DATA_W-1:0];
                c_alu  = sum[DATA_W];
              end
              OP_SUB: begin
                wr     = 1'b1;
                wr_val = diff[DATA_W-1:0];
                c_alu  = diff[DATA_W];
              end
              OP_CMP: begin
                c_alu = (bus.a < bus.b);
                z_alu = (bus.a == bus.b);
              end
              default: ;
            endcase
          end
        end
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (step_count == 3'(MUL_W-1))
          state_next = S_FIN;
      end
      S_FIN: begin
        wr         = 1'b1;
        wr_val     = product;
        c_alu      = 1'b0;
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    result_next = wr ? wr_val : result_reg;
    if (wr)
      z_alu = (wr_val == '0);

    // Direct flag control beats the ALU update; reset beats set.
    c_next = bus.creset ? 1'b0 : (bus.cset ? 1'b1 : c_alu);
    z_next = bus.zreset ? 1'b0 : (bus.zset ? 1'b1 : z_alu);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      result_reg <= '0;
      c_reg      <= 1'b0;
      z_reg      <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      c_reg      <= c_next;
      z_reg      <= z_next;
      done_reg   <= done_next;
    end
  end

  assign bus.result = result_reg;
  assign bus.cflag  = c_reg;
  assign bus.zflag  = z_reg;
  assign bus.done   = done_reg;
  assign bus.busy   = (state_reg == S_MUL);
endmodule
